// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle SLL/SRL/SRA/ROTR unit, up to STEP bit positions per cycle, start/busy/done handshake.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   signal,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     out_q, out_d, shifted, sra;
  logic [2*WIDTH-1:0]   rot;
  logic [SHAMT_W-1:0]   count_q, count_d, k;
  logic [1:0]           mode_q, mode_d;
  logic                 done_q, done_d;
  always_comb begin
    k       = (32'(count_q) < STEP) ? count_q : STEP_K;
    rot     = {out_q, out_q} >> k;
    sra     = $signed(out_q) >>> k;
    shifted = mode_q == 2'b00 ? out_q << k :
              mode_q == 2'b01 ? out_q >> k :
              mode_q == 2'b10 ? sra : rot[WIDTH-1:0];
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    mode_d  = mode_q;
    done_d  = state_q == FINISH;
    case (state_q)
      IDLE: if (start) begin
        out_d   = signal;
        count_d = shamt;
        mode_d  = mode;
        state_d = shamt == '0 ? FINISH : SHIFT;
      end
      SHIFT: begin
        out_d   = shifted;
        count_d = count_q - k;
        state_d = count_q == k ? FINISH : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      count_q <= '0;
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign out  = out_q;
endmodule
